// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the byte-serial 16-bit ALU sequencer.
// Holds command opcodes, external ALU opcodes, FSM states and the carry-select encoding.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_ORA  = 3'b011,
    OP_EOR  = 3'b100,
    OP_ASL  = 3'b101,
    OP_LSR  = 3'b110,
    OP_PASS = 3'b111
  } cmd_op_e;

  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_DBL  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1101;
  localparam logic [3:0] ALU_XOR  = 4'b1110;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CSEL_ZERO  = 2'd0,
    CSEL_CMD   = 2'd1,
    CSEL_CHAIN = 2'd2
  } csel_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Ops whose final carry comes from the ALU rather than the latched cmd_ci.
  function automatic logic uses_carry(input logic [2:0] op);
    return is_arith(op) || (op == OP_ASL) || (op == OP_LSR);
  endfunction

  function automatic logic uses_b(input logic [2:0] op);
    return is_arith(op) || (op == OP_AND) || (op == OP_ORA) || (op == OP_EOR);
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational decode of (command op, pass index) into ALU opcode,
// shift direction and carry-in source.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] cmd_op,
  input  logic       second,
  output logic [3:0] alu_op,
  output logic       alu_right,
  output csel_e      carry_sel
);

  // First pass takes carry from the command, second pass chains the ALU carry.
  always_comb begin
    alu_op    = ALU_PASS;
    alu_right = 1'b0;
    carry_sel = CSEL_ZERO;
    case (cmd_op)
      OP_ADD: begin
        alu_op    = ALU_ADD;
        carry_sel = second ? CSEL_CHAIN : CSEL_CMD;
      end
      OP_SUB: begin
        alu_op    = ALU_SUB;
        carry_sel = second ? CSEL_CHAIN : CSEL_CMD;
      end
      OP_AND:  alu_op = ALU_AND;
      OP_ORA:  alu_op = ALU_OR;
      OP_EOR:  alu_op = ALU_XOR;
      OP_ASL: begin
        alu_op    = ALU_DBL;
        carry_sel = second ? CSEL_CHAIN : CSEL_CMD;
      end
      OP_LSR: begin
        alu_op    = ALU_PASS;
        alu_right = 1'b1;
        carry_sel = second ? CSEL_CHAIN : CSEL_CMD;
      end
      OP_PASS: alu_op = ALU_PASS;
      default: begin
        alu_op    = ALU_PASS;
        alu_right = 1'b0;
        carry_sel = CSEL_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequences one 16-bit command as two byte passes through an external registered 8-bit ALU,
// then presents the assembled result and flags on a valid/ready handshake.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_ci,
  input  logic        cmd_bcd,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_c,
  output logic        res_v,
  output logic        res_z,
  output logic        res_n,
  output logic        busy,
  output logic [3:0]  alu_op,
  output logic        alu_right,
  output logic        alu_ci,
  output logic        alu_bcd,
  output logic        alu_rdy,
  output logic [7:0]  alu_ai,
  output logic [7:0]  alu_bi,
  input  logic [7:0]  alu_out,
  input  logic        alu_co,
  input  logic        alu_v,
  input  logic        alu_n
);

  state_e      state_r, state_s;
  logic [2:0]  op_r;
  logic [15:0] a_r, b_r;
  logic        ci_r, bcd_r;
  logic [7:0]  pass1_r;
  logic [15:0] res_data_r;
  logic        res_c_r, res_v_r, res_z_r, res_n_r, res_valid_r;

  logic        second_s, hi_first_s, hi_byte_s;
  logic [3:0]  dec_op_s;
  logic        dec_right_s;
  csel_e       csel_s;
  logic [15:0] res_word_s;

  // LSR walks the word high byte first so the shifted-out bit feeds the low byte.
  assign hi_first_s = (op_r == OP_LSR);
  assign second_s   = (state_r == S_P2);
  assign hi_byte_s  = second_s ^ hi_first_s;
  assign res_word_s = hi_first_s ? {pass1_r, alu_out} : {alu_out, pass1_r};

  alu_seq_decode u_decode (
    .cmd_op    (op_r),
    .second    (second_s),
    .alu_op    (dec_op_s),
    .alu_right (dec_right_s),
    .carry_sel (csel_s)
  );

  // Next-state logic; the pass and writeback states only advance with rdy.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (cmd_valid) state_s = S_P1;   else state_s = S_IDLE;
      S_P1:    if (rdy)       state_s = S_P2;   else state_s = S_P1;
      S_P2:    if (rdy)       state_s = S_WB;   else state_s = S_P2;
      S_WB:    if (rdy)       state_s = S_DONE; else state_s = S_WB;
      S_DONE:  if (res_ready) state_s = S_IDLE; else state_s = S_DONE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, command latch, pass-1 byte and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      op_r        <= 3'b000;
      a_r         <= 16'h0000;
      b_r         <= 16'h0000;
      ci_r        <= 1'b0;
      bcd_r       <= 1'b0;
      pass1_r     <= 8'h00;
      res_data_r  <= 16'h0000;
      res_c_r     <= 1'b0;
      res_v_r     <= 1'b0;
      res_z_r     <= 1'b0;
      res_n_r     <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == S_IDLE && cmd_valid) begin
        op_r  <= cmd_op;
        a_r   <= cmd_a;
        b_r   <= cmd_b;
        ci_r  <= cmd_ci;
        bcd_r <= cmd_bcd;
      end
      if (state_r == S_P2 && rdy) begin
        pass1_r <= alu_out;
      end
      if (state_r == S_WB && rdy) begin
        res_data_r  <= res_word_s;
        // alu_n is bit 7 of the high-byte pass when that pass is the second one.
        res_n_r     <= hi_first_s ? pass1_r[7] : alu_n;
        res_z_r     <= (res_word_s == 16'h0000);
        res_c_r     <= uses_carry(op_r) ? alu_co : ci_r;
        res_v_r     <= is_arith(op_r) ? alu_v : 1'b0;
        res_valid_r <= 1'b1;
      end else if (state_r == S_DONE && res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  // ALU drives are active only during the two byte passes, idle otherwise.
  always_comb begin
    alu_op    = ALU_PASS;
    alu_right = 1'b0;
    alu_ci    = 1'b0;
    alu_bcd   = 1'b0;
    alu_rdy   = 1'b0;
    alu_ai    = 8'h00;
    alu_bi    = 8'h00;
    if (state_r == S_P1 || state_r == S_P2) begin
      alu_op    = dec_op_s;
      alu_right = dec_right_s;
      alu_rdy   = rdy;
      alu_bcd   = bcd_r & is_arith(op_r);
      alu_ai    = hi_byte_s ? a_r[15:8] : a_r[7:0];
      if (uses_b(op_r)) begin
        alu_bi = hi_byte_s ? b_r[15:8] : b_r[7:0];
      end else begin
        alu_bi = 8'h00;
      end
      case (csel_s)
        CSEL_CMD:   alu_ci = ci_r;
        CSEL_CHAIN: alu_ci = alu_co;
        default:    alu_ci = 1'b0;
      endcase
    end else begin
      alu_op  = ALU_PASS;
      alu_rdy = 1'b0;
    end
  end

  assign cmd_ready = (state_r == S_IDLE);
  assign busy      = (state_r != S_IDLE);
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_c     = res_c_r;
  assign res_v     = res_v_r;
  assign res_z     = res_z_r;
  assign res_n     = res_n_r;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: hosts a registered 8-bit ALU and compares every command
// against a 16-bit word-level reference computed from the operation definitions.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0, reset = 1'b1, rdy = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_ci = 1'b0, cmd_bcd = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_a = 16'h0000, cmd_b = 16'h0000;
  logic        res_valid, res_ready = 1'b0, res_c, res_v, res_z, res_n, busy;
  logic [15:0] res_data;
  logic [3:0]  alu_op;
  logic        alu_right, alu_ci, alu_bcd, alu_rdy;
  logic [7:0]  alu_ai, alu_bi;
  logic [7:0]  alu_out = 8'h00;
  logic        alu_co = 1'b0, alu_v = 1'b0, alu_n;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .reset(reset), .rdy(rdy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ci(cmd_ci), .cmd_bcd(cmd_bcd),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_c(res_c), .res_v(res_v), .res_z(res_z), .res_n(res_n), .busy(busy),
    .alu_op(alu_op), .alu_right(alu_right), .alu_ci(alu_ci), .alu_bcd(alu_bcd),
    .alu_rdy(alu_rdy), .alu_ai(alu_ai), .alu_bi(alu_bi),
    .alu_out(alu_out), .alu_co(alu_co), .alu_v(alu_v), .alu_n(alu_n)
  );

  function automatic int dec8(input logic [7:0] x);
    return int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [7:0] bcd8(input int d);
    logic [7:0] r;
    r[7:4] = 4'(d / 10);
    r[3:0] = 4'(d % 10);
    return r;
  endfunction

  function automatic int dec16(input logic [15:0] x);
    return dec8(x[15:8]) * 100 + dec8(x[7:0]);
  endfunction

  function automatic logic [15:0] bcd16(input int d);
    return {bcd8(d / 100), bcd8(d % 100)};
  endfunction

  // Byte ALU: SUB is A + ~B + ci (ci = not-borrow); right shift takes ci in at bit 7.
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] ai, input logic [7:0] bi,
                                        input logic ci, input logic bcd, input logic right);
    logic [8:0] s;
    logic [7:0] r;
    logic       co, v;
    int         d;
    r = ai; co = 1'b0; v = 1'b0;
    case (op)
      4'b0011: if (bcd) begin
                 d = dec8(ai) + dec8(bi) + int'(ci); co = (d >= 100); r = bcd8(d % 100);
               end else begin
                 s = {1'b0, ai} + {1'b0, bi} + {8'd0, ci}; r = s[7:0]; co = s[8];
                 v = (ai[7] == bi[7]) && (r[7] != ai[7]);
               end
      4'b0111: if (bcd) begin
                 d = dec8(ai) - dec8(bi) - (ci ? 0 : 1); co = (d >= 0);
                 if (d < 0) d = d + 100;
                 r = bcd8(d);
               end else begin
                 s = {1'b0, ai} + {1'b0, ~bi} + {8'd0, ci}; r = s[7:0]; co = s[8];
                 v = (ai[7] != bi[7]) && (r[7] != ai[7]);
               end
      4'b1011: begin s = {1'b0, ai} + {1'b0, ai} + {8'd0, ci}; r = s[7:0]; co = s[8]; end
      4'b1100: r = ai | bi;
      4'b1101: r = ai & bi;
      4'b1110: r = ai ^ bi;
      default: r = ai;
    endcase
    if (right) begin
      co = r[0];
      r  = {ci, r[7:1]};
    end
    return {co, v, r};
  endfunction

  always @(posedge clk) begin
    if (alu_rdy) begin
      {alu_co, alu_v, alu_out} <= alu_fn(alu_op, alu_ai, alu_bi, alu_ci, alu_bcd, alu_right);
    end
  end
  assign alu_n = alu_out[7];

  // Word-level reference: returns {carry, overflow, data}.
  function automatic logic [17:0] ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic bcd);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, v;
    int          d;
    r = a; c = ci; v = 1'b0;
    case (op)
      3'd0: if (bcd) begin
              d = dec16(a) + dec16(b) + int'(ci); c = (d >= 10000); r = bcd16(d % 10000);
            end else begin
              s = {1'b0, a} + {1'b0, b} + {16'd0, ci}; r = s[15:0]; c = s[16];
              v = (a[15] == b[15]) && (r[15] != a[15]);
            end
      3'd1: if (bcd) begin
              d = dec16(a) - dec16(b) - (ci ? 0 : 1); c = (d >= 0);
              if (d < 0) d = d + 10000;
              r = bcd16(d);
            end else begin
              s = {1'b0, a} + {1'b0, ~b} + {16'd0, ci}; r = s[15:0]; c = s[16];
              v = (a[15] != b[15]) && (r[15] != a[15]);
            end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = {a[14:0], ci}; c = a[15]; end
      3'd6: begin r = {ci, a[15:1]}; c = a[0]; end
      default: r = a;
    endcase
    return {c, v, r};
  endfunction

  function automatic logic [15:0] rand_bcd16();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One command from IDLE to handshake-out; stall = rdy-low cycles in P2, hold = res_ready-low cycles in DONE.
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic bcd, input int stall, input int hold, output logic p2ci);
    logic [17:0] exp;
    logic [7:0]  byte1, byte2;
    int          lat;
    exp   = ref_model(op, a, b, ci, bcd);
    byte1 = (op == 3'd6) ? a[15:8] : a[7:0];
    byte2 = (op == 3'd6) ? a[7:0] : a[15:8];
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_ci = ci; cmd_bcd = bcd;
    rdy = 1'b1; res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk); lat = 1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
    cmd_ci = 1'($urandom); cmd_bcd = 1'($urandom);
    chk("p1_busy", busy, 1);
    chk("p1_alu_rdy", alu_rdy, 1);
    chk("p1_alu_ai", alu_ai, byte1);
    chk("p1_alu_right", alu_right, (op == 3'd6));
    chk("p1_alu_ci", alu_ci, (op inside {3'd0, 3'd1, 3'd5, 3'd6}) ? ci : 1'b0);
    chk("p1_alu_bcd", alu_bcd, (op inside {3'd0, 3'd1}) ? bcd : 1'b0);
    @(negedge clk); lat = 2;
    chk("p2_alu_ai", alu_ai, byte2);
    p2ci = alu_ci;
    if (stall > 0) begin
      rdy = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk); lat++;
        chk("stall_alu_rdy", alu_rdy, 0);
        chk("stall_alu_ai", alu_ai, byte2);
        chk("stall_alu_ci", alu_ci, p2ci);
      end
      rdy = 1'b1;
    end
    while (res_valid !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    chk("latency", lat, 4 + stall);
    chk("res_data", res_data, exp[15:0]);
    chk("res_c", res_c, exp[17]);
    chk("res_v", res_v, exp[16]);
    chk("res_z", res_z, (exp[15:0] == 16'h0000));
    chk("res_n", res_n, exp[15]);
    cmd_valid = (hold > 0);
    rdy = 1'($urandom);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, exp[15:0]);
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", cmd_ready, 1);
    chk("release_res_valid", res_valid, 0);
    res_ready = 1'b0; rdy = 1'b1;
  endtask

  initial begin
    logic        p2ci;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        bcd;
    int          acc_q[$];

    // Reset state.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 16'h0000);
    chk("rst_alu_op", alu_op, 4'b1111);
    chk("rst_alu_ai", alu_ai, 8'h00);
    chk("rst_alu_rdy", alu_rdy, 0);

    // Directed cases.
    run_cmd(3'd0, 16'h12FF, 16'h0001, 1'b0, 1'b0, 0, 0, p2ci);
    chk("add_p2_alu_ci", p2ci, 1);
    run_cmd(3'd1, 16'h0000, 16'h0001, 1'b1, 1'b0, 0, 0, p2ci);
    run_cmd(3'd6, 16'h0101, 16'hBEEF, 1'b0, 1'b0, 0, 0, p2ci);
    run_cmd(3'd6, 16'h1234, 16'h0000, 1'b1, 1'b0, 0, 0, p2ci);
    run_cmd(3'd5, 16'h8000, 16'h5555, 1'b0, 1'b0, 0, 0, p2ci);
    run_cmd(3'd5, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 0, p2ci);
    run_cmd(3'd0, 16'h0999, 16'h0001, 1'b0, 1'b1, 0, 0, p2ci);
    run_cmd(3'd1, 16'h0000, 16'h0001, 1'b1, 1'b1, 0, 0, p2ci);
    run_cmd(3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0, p2ci);
    run_cmd(3'd0, 16'h12FF, 16'h0001, 1'b0, 1'b0, 3, 0, p2ci);
    run_cmd(3'd4, 16'hA5A5, 16'h0FF0, 1'b1, 1'b0, 0, 5, p2ci);

    // Reset while the command is in P2 drops it.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 16'h1111; cmd_b = 16'h2222; cmd_ci = 1'b0; cmd_bcd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_alu_op", alu_op, 4'b1111);
    chk("midrst_res_data", res_data, 16'h0000);
    chk("midrst_res_c", res_c, 0);
    repeat (6) @(negedge clk);
    chk("midrst_no_result", res_valid, 0);

    // Randomized commands against the reference model.
    for (int n = 0; n < 60; n++) begin
      op  = 3'($urandom_range(0, 7));
      bcd = (op inside {3'd0, 3'd1}) ? 1'($urandom) : 1'($urandom);
      if (bcd && (op inside {3'd0, 3'd1})) begin
        a = rand_bcd16(); b = rand_bcd16();
      end else begin
        a = 16'($urandom); b = 16'($urandom);
      end
      run_cmd(op, a, b, 1'($urandom), bcd, $urandom_range(0, 2), $urandom_range(0, 2), p2ci);
    end

    // Back-to-back commands with res_ready held high: accepts every 5 cycles.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 16'h0102; cmd_b = 16'h0304; res_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (cmd_ready) acc_q.push_back(i);
      chk("no_accept_in_done", cmd_ready & res_valid, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("spacing_count", acc_q.size(), 3);
    for (int i = 1; i < acc_q.size(); i++) chk("spacing_gap", acc_q[i] - acc_q[i-1], 5);
    repeat (8) @(negedge clk);
    chk("final_idle", cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
